// File: rtl/wave_former_pkg.sv
// Shared types and helpers for the wave_former CORDIC front-ends.
// Holds the phase generator state encoding, the CORDIC gain constant and saturating negation.
package wave_former_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } phase_gen_state_t;

  // 1/1.6468 in Q1.15; callers pre-scale amplitudes by this to cancel the CORDIC gain.
  localparam logic [15:0] CORDIC_GAIN_INV = 16'd19898;

  // Negates a w-bit two's-complement value carried sign-extended in 32 bits.
  // The most negative value has no positive counterpart, so it clamps to the maximum.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] a, input int w);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (w - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    return (a == min_v) ? max_v : -a;
  endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Combinational fold of an angle/amplitude pair into the CORDIC convergence range (+/- pi/2).
// Angles in quadrants 2 and 3 are rotated by pi and the amplitude negated to compensate.
module cordic_quadrant_fold
  import wave_former_pkg::*;
#(
  parameter int XY_WIDTH = 16,
  parameter int Z_WIDTH  = 16
) (
  input  logic [Z_WIDTH-1:0]  p,
  input  logic [XY_WIDTH-1:0] amp,
  output logic [Z_WIDTH-1:0]  z,
  output logic [XY_WIDTH-1:0] x
);

  logic                flip;
  logic [XY_WIDTH-1:0] neg_amp;

  // Top two bits 01 or 10 mean the angle lies outside [-pi/2, pi/2).
  assign flip    = p[Z_WIDTH-1] ^ p[Z_WIDTH-2];
  assign neg_amp = XY_WIDTH'(sat_neg(32'(signed'(amp)), XY_WIDTH));

  assign z = flip ? {~p[Z_WIDTH-1], p[Z_WIDTH-2:0]} : p;
  assign x = flip ? neg_amp : amp;

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO phase generator feeding the rotation-mode CORDIC: accumulator, sample-rate divider,
// shadowed FTW applied at period wrap, period-aligned stop, and a two-stage output pipeline.
module cordic_phase_gen
  import wave_former_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int XY_WIDTH    = 16,
  parameter int Z_WIDTH     = 16,
  parameter int RATE_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   run,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_load,
  input  logic [Z_WIDTH-1:0]     phase_offset_in,
  input  logic [XY_WIDTH-1:0]    amp_in,
  input  logic [RATE_WIDTH-1:0]  rate_div,
  output logic                   valid_out,
  output logic [XY_WIDTH-1:0]    x_out,
  output logic [XY_WIDTH-1:0]    y_out,
  output logic [Z_WIDTH-1:0]     z_out,
  output logic                   wrap_out,
  output logic                   busy_out
);

  phase_gen_state_t       state, state_nx;
  logic [RATE_WIDTH-1:0]  cnt;
  logic [PHASE_WIDTH-1:0] acc, acc_sum;
  logic [PHASE_WIDTH-1:0] ftw_active, shadow, shadow_nx;
  logic                   carry, strobe, wrap;

  // Sample stage: angle and amplitude captured on the strobe, folded one cycle later.
  logic                   s_valid, s_wrap;
  logic [Z_WIDTH-1:0]     s_p;
  logic [XY_WIDTH-1:0]    s_amp;
  logic [Z_WIDTH-1:0]     f_z;
  logic [XY_WIDTH-1:0]    f_x;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    shadow_nx        = ftw_load ? ftw_in : shadow;
    {carry, acc_sum} = {1'b0, acc} + {1'b0, ftw_active};
    strobe           = (state != IDLE) && (cnt == '0);
    wrap             = strobe && carry;
    state_nx         = state;
    case (state)
      IDLE:     if (run) state_nx = RUN;
      RUN:      if (!run) state_nx = STOPPING;
      STOPPING: begin
        if (run)       state_nx = RUN;
        else if (wrap) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy_out   <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      shadow     <= '0;
      ftw_active <= '0;
      s_valid    <= 1'b0;
      s_wrap     <= 1'b0;
      s_p        <= '0;
      s_amp      <= '0;
    end else if (en) begin
      state    <= state_nx;
      busy_out <= (state_nx != IDLE);
      shadow   <= shadow_nx;
      if (state == IDLE) begin
        acc <= '0;
        cnt <= '0;
        if (ftw_load) ftw_active <= ftw_in;
      end else if (strobe) begin
        cnt <= rate_div;
        acc <= (state_nx == IDLE) ? '0 : acc_sum;
        // A load landing on the wrap cycle is taken here via shadow_nx.
        if (carry) ftw_active <= shadow_nx;
      end else begin
        cnt <= cnt - RATE_WIDTH'(1);
      end
      s_valid <= strobe;
      s_wrap  <= wrap;
      if (strobe) begin
        s_p   <= acc[PHASE_WIDTH-1 -: Z_WIDTH] + phase_offset_in;
        s_amp <= amp_in;
      end
    end
  end

  cordic_quadrant_fold #(
    .XY_WIDTH (XY_WIDTH),
    .Z_WIDTH  (Z_WIDTH)
  ) u_fold (
    .p   (s_p),
    .amp (s_amp),
    .z   (f_z),
    .x   (f_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      wrap_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (en) begin
      valid_out <= s_valid;
      wrap_out  <= s_wrap;
      y_out     <= '0;
      if (s_valid) begin
        x_out <= f_x;
        z_out <= f_z;
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed, table-driven bench for cordic_phase_gen with hand-computed expectations.
module tb_cordic_phase_gen;

  logic        clk = 1'b0;
  logic        rst, en, run, ftw_load;
  logic [31:0] ftw_in;
  logic [15:0] phase_offset_in, amp_in, rate_div;
  logic        valid_out, wrap_out, busy_out;
  logic [15:0] x_out, y_out, z_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] amp;
    logic [15:0] off;
    logic [15:0] z;
    logic [15:0] x;
    logic        wrap;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] ftw_z[14];
  logic [15:0] ftw_x[14];
  logic [13:0] ftw_w;
  logic [10:1] div_v;

  cordic_phase_gen dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .run             (run),
    .ftw_in          (ftw_in),
    .ftw_load        (ftw_load),
    .phase_offset_in (phase_offset_in),
    .amp_in          (amp_in),
    .rate_div        (rate_div),
    .valid_out       (valid_out),
    .x_out           (x_out),
    .y_out           (y_out),
    .z_out           (z_out),
    .wrap_out        (wrap_out),
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_sample(input string tag, input logic [15:0] z, input logic [15:0] x,
                              input logic w);
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_z"}, 32'(z_out), 32'(z));
    check({tag, "_x"}, 32'(x_out), 32'(x));
    check({tag, "_wrap"}, 32'(wrap_out), 32'(w));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_x"}, 32'(x_out), 32'd0);
    check({tag, "_y"}, 32'(y_out), 32'd0);
    check({tag, "_z"}, 32'(z_out), 32'd0);
    check({tag, "_wrap"}, 32'(wrap_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; run = 1'b0; ftw_load = 1'b0; ftw_in = '0;
    phase_offset_in = '0; amp_in = 16'h4000; rate_div = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Load a tuning word while IDLE, which sets the active FTW immediately.
  task automatic load_idle(input logic [31:0] ftw);
    ftw_in = ftw; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0; ftw_in = '0;
  endtask

  initial begin
    // Quadrant sweep plus amplitude/offset corners; acc steps by 0x4000 in the top 16 bits.
    vecs[0] = '{16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0};
    vecs[1] = '{16'h4000, 16'h0000, 16'hC000, 16'hC000, 1'b0};
    vecs[2] = '{16'h4000, 16'h0000, 16'h0000, 16'hC000, 1'b0};
    vecs[3] = '{16'h4000, 16'h0000, 16'hC000, 16'h4000, 1'b1};
    vecs[4] = '{16'h8000, 16'h4000, 16'hC000, 16'h7FFF, 1'b0};
    vecs[5] = '{16'h1234, 16'h8000, 16'hC000, 16'h1234, 1'b0};
    vecs[6] = '{16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0};
    vecs[7] = '{16'hFF9C, 16'h2000, 16'hE000, 16'hFF9C, 1'b1};
    vecs[8] = '{16'h0100, 16'h3000, 16'h3000, 16'h0100, 1'b0};
    vecs[9] = '{16'h0100, 16'h3000, 16'hF000, 16'hFF00, 1'b0};

    // FTW update run: acc tops 0,4,8,C | 0,2,4,6,8,A,C,E | 0,8 (x 0x1000).
    ftw_z = '{16'h0000, 16'hC000, 16'h0000, 16'hC000, 16'h0000, 16'h2000, 16'hC000,
              16'hE000, 16'h0000, 16'h2000, 16'hC000, 16'hE000, 16'h0000, 16'h0000};
    ftw_x = '{16'h4000, 16'hC000, 16'hC000, 16'h4000, 16'h4000, 16'h4000, 16'hC000,
              16'hC000, 16'hC000, 16'hC000, 16'h4000, 16'h4000, 16'h4000, 16'hC000};
    ftw_w = 14'b10_1000_0000_1000;
    div_v = 10'b11_1001_0010;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // Quadrants and table corners
    load_idle(32'h4000_0000);
    run = 1'b1;
    tick();
    check("quad_busy", 32'(busy_out), 32'd1);
    check("quad_lat0", 32'(valid_out), 32'd0);
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        amp_in = vecs[i].amp;
        phase_offset_in = vecs[i].off;
      end
      tick();
      if (i == 0) check("quad_lat1", 32'(valid_out), 32'd0);
      else check_sample($sformatf("quad%0d", i - 1), vecs[i-1].z, vecs[i-1].x, vecs[i-1].wrap);
    end

    // Reset mid-run with en low; restart with zero FTW gives a constant phase.
    en = 1'b0; rst = 1'b1;
    tick();
    check_idle_outputs("rst_midrun");
    rst = 1'b0; en = 1'b1; amp_in = 16'h4000; phase_offset_in = 16'h1000;
    tick();
    check("restart_lat0", 32'(valid_out), 32'd0);
    check("restart_busy", 32'(busy_out), 32'd1);
    tick();
    check("restart_lat1", 32'(valid_out), 32'd0);
    tick();
    check_sample("restart", 16'h1000, 16'h4000, 1'b0);
    phase_offset_in = 16'h8000;
    tick();
    tick();
    check_sample("offset_pi", 16'h0000, 16'hC000, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("stopping_nowrap_busy", 32'(busy_out), 32'd1);
    check("stopping_nowrap_wrap", 32'(wrap_out), 32'd0);

    // Divider: rate 2, then 0 taking effect after the current countdown.
    do_reset();
    load_idle(32'h4000_0000);
    rate_div = 16'd2; run = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      rate_div = (i >= 5) ? 16'd0 : 16'd2;
      tick();
      check($sformatf("div_valid%0d", i), 32'(valid_out), 32'(div_v[i]));
      check($sformatf("div_wrap%0d", i), 32'(wrap_out), 32'(i == 9));
      if (div_v[i])
        check($sformatf("div_z%0d", i), 32'(z_out), (i == 5 || i == 9) ? 32'hC000 : 32'h0);
    end

    // FTW update: mid-period load waits for the wrap; a load on the wrap cycle applies there.
    do_reset();
    load_idle(32'h4000_0000);
    run = 1'b1;
    tick();
    for (int i = 0; i <= 14; i++) begin
      ftw_load = (i == 1 || i == 11);
      ftw_in = (i == 1) ? 32'h2000_0000 : ((i == 11) ? 32'h8000_0000 : 32'h0);
      tick();
      if (i >= 1)
        check_sample($sformatf("ftw%0d", i - 1), ftw_z[i-1], ftw_x[i-1], ftw_w[i-1]);
    end
    ftw_load = 1'b0;

    // Stop after sample 2: remaining samples of the period are emitted, then IDLE.
    do_reset();
    load_idle(32'h4000_0000);
    run = 1'b1;
    tick();
    for (int i = 0; i <= 6; i++) begin
      run = (i < 2);
      tick();
      check($sformatf("stop_valid%0d", i), 32'(valid_out), 32'(i >= 1 && i <= 4));
      check($sformatf("stop_wrap%0d", i), 32'(wrap_out), 32'(i == 4));
      check($sformatf("stop_busy%0d", i), 32'(busy_out), 32'(i < 3));
    end

    // Re-raising run in STOPPING returns to RUN and continues past the wrap.
    run = 1'b1;
    tick();
    for (int i = 0; i <= 7; i++) begin
      run = (i != 1);
      tick();
      check($sformatf("rerun_busy%0d", i), 32'(busy_out), 32'd1);
      check($sformatf("rerun_valid%0d", i), 32'(valid_out), 32'(i >= 1));
      if (i == 1) check("rerun_z0", 32'(z_out), 32'h0);
    end

    // en low for 5 cycles freezes everything; the sequence then resumes unchanged.
    do_reset();
    load_idle(32'h4000_0000);
    run = 1'b1;
    tick();
    tick();
    tick();
    check_sample("pre_freeze", 16'h0000, 16'h4000, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_sample($sformatf("freeze%0d", i), 16'h0000, 16'h4000, 1'b0);
      check($sformatf("freeze_busy%0d", i), 32'(busy_out), 32'd1);
    end
    en = 1'b1;
    tick();
    check_sample("resume1", 16'hC000, 16'hC000, 1'b0);
    tick();
    check_sample("resume2", 16'h0000, 16'hC000, 1'b0);
    tick();
    check_sample("resume3", 16'hC000, 16'h4000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
